// File: rtl/match_controller.sv
// match_controller
// Sequences a Pong match: holds the ball before each serve, launches it,
// scores missed balls, and detects the winner.
//
// Parameters:
//   WIN_SCORE          points needed to win (1..9)
//   SERVE_DELAY_FRAMES frames the ball is held before each serve (1..255)
//
// Ports:
//   clk        system clock
//   RESET      asynchronous active-low reset
//   vsync      VGA VSync (active-low, asynchronous to clk)
//   start      start/restart request, active-high level
//   miss_left  one-cycle pulse, ball passed the left paddle
//   miss_right one-cycle pulse, ball passed the right paddle
//   ball_run   ball may move (low holds the ball at centre)
//   serve      one-cycle pulse launching the ball
//   serve_dir  launch direction: 0 toward left player, 1 toward right player
//   paddle_en  paddles respond to keys
//   score1     left player score (binary)
//   score2     right player score (binary)
//   game_over  match has ended
//   winner     0 left won, 1 right won (valid while game_over)
//   state      debug state code: IDLE=0, SERVE=1, PLAY=2, GAME_OVER=3

module match_controller #(
  parameter int WIN_SCORE          = 5,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       vsync,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_run,
  output logic       serve,
  output logic       serve_dir,
  output logic       paddle_en,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_GAME_OVER = 3'd3
  } state_t;

  localparam logic [3:0] WIN_PTS     = WIN_SCORE[3:0];
  localparam logic [7:0] SERVE_DELAY = SERVE_DELAY_FRAMES[7:0];

  state_t     cur_state;
  logic [7:0] frame_cnt;

  logic vsync_meta, vsync_sync, vsync_prev;
  logic start_meta, start_sync, start_prev;
  logic frame_tick, start_edge;
  logic [3:0] score1_inc, score2_inc;

  // Two-flop synchronizers plus one edge-detect register per input.
  // vsync idles high, so its flops reset to 1 to avoid a false frame tick.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      vsync_meta <= 1'b1;
      vsync_sync <= 1'b1;
      vsync_prev <= 1'b1;
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      vsync_meta <= vsync;
      vsync_sync <= vsync_meta;
      vsync_prev <= vsync_sync;
      start_meta <= start;
      start_sync <= start_meta;
      start_prev <= start_sync;
    end
  end

  assign frame_tick = vsync_prev & ~vsync_sync;
  assign start_edge = start_sync & ~start_prev;

  assign score1_inc = score1 + 4'd1;
  assign score2_inc = score2 + 4'd1;

  assign state = cur_state;

  // Match FSM with all outputs registered alongside the state, so serve,
  // ball_run and the state code always change on the same edge.
  // A start edge restarts the match from any state and overrides a miss.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cur_state <= ST_IDLE;
      frame_cnt <= 8'd0;
      score1    <= 4'd0;
      score2    <= 4'd0;
      serve     <= 1'b0;
      serve_dir <= 1'b0;
      ball_run  <= 1'b0;
      paddle_en <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      serve <= 1'b0;
      if (start_edge) begin
        cur_state <= ST_SERVE;
        frame_cnt <= SERVE_DELAY;
        score1    <= 4'd0;
        score2    <= 4'd0;
        serve_dir <= 1'b0;
        ball_run  <= 1'b0;
        paddle_en <= 1'b1;
        game_over <= 1'b0;
        winner    <= 1'b0;
      end else begin
        case (cur_state)
          ST_SERVE: begin
            if (frame_tick) begin
              frame_cnt <= frame_cnt - 8'd1;
              if (frame_cnt == 8'd1) begin
                serve     <= 1'b1;
                ball_run  <= 1'b1;
                cur_state <= ST_PLAY;
              end
            end
          end
          ST_PLAY: begin
            if (miss_left || miss_right) begin
              ball_run <= 1'b0;
              // Only one side scores per rally; the left miss wins a tie.
              if (miss_left) begin
                score2    <= score2_inc;
                serve_dir <= 1'b0;
                winner    <= 1'b1;
              end else begin
                score1    <= score1_inc;
                serve_dir <= 1'b1;
                winner    <= 1'b0;
              end
              if ((miss_left && score2_inc == WIN_PTS) ||
                  (!miss_left && score1_inc == WIN_PTS)) begin
                cur_state <= ST_GAME_OVER;
                paddle_en <= 1'b0;
                game_over <= 1'b1;
              end else begin
                cur_state <= ST_SERVE;
                frame_cnt <= SERVE_DELAY;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/match_controller.md
# match_controller

Sequences a Pong match on top of the ball and paddle datapath. It decides when the ball is held, served and running, keeps both scores and detects the winner. It sits between the ball/paddle blocks and the seven-segment controller in the FPGA_CLK domain. Miss events come from the ball block, and frame timing comes from the VGA sync generator.

## Interface
- WIN_SCORE, 5: points needed to win; legal range 1..9.
- SERVE_DELAY_FRAMES, 60: number of frames the ball is held before each serve; legal range 1..255.
- clk  in  1  system clock (FPGA_CLK domain).
- RESET  in  1  asynchronous, active-low reset.
- vsync  in  1  VGA VSync, active-low, from another clock domain.
- start  in  1  start/restart request, active-high level (button already inverted).
- miss_left  in  1  one-cycle pulse: the ball passed the left paddle.
- miss_right  in  1  one-cycle pulse: the ball passed the right paddle.
- ball_run  out  1  ball may move; when low, the ball block holds the ball at centre.
- serve  out  1  one-cycle pulse that launches the ball.
- serve_dir  out  1  launch direction: 0 = toward the left player, 1 = toward the right player.
- paddle_en  out  1  paddles respond to keys.
- score1  out  4  left player score, binary 0..9.
- score2  out  4  right player score, binary 0..9.
- game_over  out  1  the match has ended.
- winner  out  1  0 = left player won, 1 = right player won; valid only while game_over is high.
- state  out  3  debug code: IDLE=0, SERVE=1, PLAY=2, GAME_OVER=3.

## Operation
- Input conditioning:
  - vsync and start each pass through a two-flop synchronizer and then an edge-detect register.
  - frame_tick is the falling edge of the synchronized vsync.
  - start_edge is the rising edge of the synchronized start.
  - miss_left and miss_right are already in the clk domain and are used without synchronization.
- Frame counter: 8-bit down-counter used only in SERVE.
- IDLE:
  - Outputs: ball_run=0, paddle_en=0.
  - On start_edge: clear both scores, load the counter with SERVE_DELAY_FRAMES, set serve_dir=0, go to SERVE.
- SERVE:
  - Outputs: ball_run=0, paddle_en=1.
  - Each frame_tick decrements the counter.
  - A frame_tick while the counter==1 pulses serve for one cycle and goes to PLAY.
- PLAY:
  - Outputs: ball_run=1, paddle_en=1.
  - miss_left: score2 increments by 1 and serve_dir becomes 0.
  - Otherwise miss_right: score1 increments by 1 and serve_dir becomes 1.
  - miss_left has priority when both pulses arrive together; exactly one point is scored per rally.
  - If the incremented score equals WIN_SCORE: go to GAME_OVER, with winner set to the scoring side.
  - Otherwise: reload the counter and go to SERVE.
- GAME_OVER:
  - Outputs: ball_run=0, paddle_en=0, game_over=1.
  - Scores and winner are held.
  - On start_edge: new match, same actions as start_edge in IDLE.
- start_edge in SERVE or PLAY restarts the match (scores cleared, SERVE entered). It takes priority over a simultaneous miss.
- miss_left and miss_right are ignored outside PLAY.
- Scores never exceed WIN_SCORE, so no wrap-around is possible.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State: IDLE.
  - Outputs: score1=0, score2=0, serve=0, serve_dir=0, ball_run=0, paddle_en=0, game_over=0, winner=0, state=0.
  - Synchronizer and edge registers: vsync flops reset to 1, start flops reset to 0, counter reset to 0.
- All outputs are registered. serve, ball_run and the state change share the same clock edge.
- A miss sampled high at edge N updates the score, state and serve_dir at edge N, so outputs are visible after edge N.
- start rising before edge K produces the state/score change at edge K+2: two synchronizer edges, then one edge for the edge-detect/FSM update.
- A vsync falling edge is seen as frame_tick with the same two-edge synchronizer latency; the FSM acts at the following edge.
- serve follows entry to SERVE by SERVE_DELAY_FRAMES frame_ticks. A frame_tick coinciding with the entry edge is not counted.
- A start held high produces one restart only. Releasing and re-pressing it produces another.
- RESET asserted mid-operation forces the reset values immediately; no serve pulse is emitted.

## Test plan
- Reset values: hold RESET=0 with random inputs, then release → all outputs at their reset values and state=0; miss pulses in IDLE leave the scores at 0.
- Serve delay: SERVE_DELAY_FRAMES=3, pulse start, then 3 vsync falls → exactly one serve pulse after the third frame_tick, state=2, ball_run=1; no serve after only 2 frames.
- Scoring: in PLAY, pulse miss_left → score2=1, serve_dir=0, state=1; after the serve delay, pulse miss_right → score1=1, serve_dir=1.
- Simultaneous misses: miss_left and miss_right in the same cycle during PLAY → score2 increments only and score1 is unchanged.
- Win: WIN_SCORE=2, two miss_right points → after the second point score1=2, game_over=1, winner=0, state=3, paddle_en=0; further misses are ignored; start → scores 0, state=1.
- Restart and reset mid-game: start_edge during PLAY with a simultaneous miss → scores 0, state=1, no increment; RESET low during SERVE → IDLE immediately, no serve pulse.
